// File: rtl/vipmod_window_ctrl_3x3.sv
// Window sequencer for the 1-bit 3x3 matrix stream: tracks position, runs the
// per-frame FILL/ACTIVE FSM and qualifies full windows. VIPMOD_WIN_ERR_EN adds a line-length checker.
module vipmod_window_ctrl_3x3 #(
  parameter logic [9:0] IMG_HDISP = 10'd640,
  parameter logic [9:0] IMG_VDISP = 10'd480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m_vsync,
  input  logic       m_href,
  input  logic       m_clken,
  output logic       win_vsync,
  output logic       win_href,
  output logic       win_valid,
  output logic [9:0] win_x,
  output logic [9:0] win_y,
  output logic       frame_done,
  output logic       frame_abort,
  output logic       line_err,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state;
  state_t     state_hs;
  state_t     state_nxt;
  logic [9:0] col_cnt;
  logic [9:0] row_cnt;
  logic       vs_rise;
  logic       vs_fall;
  logic       hs_fall;
  logic       pix;
  logic       row_inc;
  logic       valid_nxt;
  logic       done_nxt;
  logic       abort_nxt;

  assign state_dbg = state;

  // win_vsync/win_href double as the edge-detect registers.
  always_comb begin
    vs_rise   = m_vsync & ~win_vsync;
    vs_fall   = ~m_vsync & win_vsync;
    hs_fall   = ~m_href & win_href;
    pix       = m_href & m_clken;
    row_inc   = hs_fall & ((state == FILL) | (state == ACTIVE)) & (row_cnt != 10'h3FF);
    // win_valid is a pure per-cycle qualifier: no backpressure, a window is
    // present exactly in the cycle it is high, and x/y are stable with it.
    valid_nxt = (state == ACTIVE) & pix & (col_cnt >= 10'd2);
  end

  // hs_fall resolves first so a coincident vs_fall sees the post-line state.
  always_comb begin
    state_hs = state;
    if (hs_fall) begin
      if ((state == FILL) && (row_cnt == 10'd1))
        state_hs = ACTIVE;
      else if ((state == ACTIVE) && (row_cnt == IMG_VDISP - 10'd1))
        state_hs = DONE;
    end
    state_nxt = state_hs;
    done_nxt  = 1'b0;
    abort_nxt = 1'b0;
    if (vs_rise) begin
      state_nxt = FILL;
    end else if (vs_fall) begin
      state_nxt = IDLE;
      done_nxt  = (state_hs == DONE);
      abort_nxt = (state_hs == FILL) | (state_hs == ACTIVE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      win_vsync   <= 1'b0;
      win_href    <= 1'b0;
      col_cnt     <= 10'd0;
      row_cnt     <= 10'd0;
      win_valid   <= 1'b0;
      win_x       <= 10'd0;
      win_y       <= 10'd0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      state       <= state_nxt;
      win_vsync   <= m_vsync;
      win_href    <= m_href;
      frame_done  <= done_nxt;
      frame_abort <= abort_nxt;
      win_valid   <= valid_nxt;

      if (hs_fall)
        col_cnt <= 10'd0;
      else if (pix && (col_cnt != 10'h3FF))
        col_cnt <= col_cnt + 10'd1;

      if (vs_rise)
        row_cnt <= 10'd0;
      else if (row_inc)
        row_cnt <= row_cnt + 10'd1;

      // Centre of the window whose bottom-right pixel arrives this cycle.
      if (vs_rise) begin
        win_x <= 10'd0;
        win_y <= 10'd0;
      end else if (valid_nxt) begin
        win_x <= col_cnt - 10'd1;
        win_y <= row_cnt - 10'd1;
      end
    end
  end

`ifdef VIPMOD_WIN_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      line_err <= 1'b0;
    else if (vs_rise)
      line_err <= 1'b0;
    else if (hs_fall && (col_cnt != IMG_HDISP))
      line_err <= 1'b1;
  end
`else
  assign line_err = 1'b0;
`endif

endmodule

// File: tb/tb_vipmod_window_ctrl_3x3.sv
// Randomized bench for vipmod_window_ctrl_3x3 on an 8x6 frame: expected windows
// come from line/pixel indices of the generated stream, checked by a scoreboard.
module tb_vipmod_window_ctrl_3x3;

  localparam int H = 8;
  localparam int V = 6;

  logic       clk;
  logic       rst_n;
  logic       m_vsync;
  logic       m_href;
  logic       m_clken;
  logic       win_vsync;
  logic       win_href;
  logic       win_valid;
  logic [9:0] win_x;
  logic [9:0] win_y;
  logic       frame_done;
  logic       frame_abort;
  logic       line_err;
  logic [1:0] state_dbg;

  logic [19:0] exp_q[$];
  logic [19:0] exp_e;
  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_push   = 0;
  int n_done   = 0;
  int n_abort  = 0;
  bit mon_en   = 0;
  bit last_pix = 0;

  vipmod_window_ctrl_3x3 #(
    .IMG_HDISP(10'd8),
    .IMG_VDISP(10'd6)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m_vsync    (m_vsync),
    .m_href     (m_href),
    .m_clken    (m_clken),
    .win_vsync  (win_vsync),
    .win_href   (win_href),
    .win_valid  (win_valid),
    .win_x      (win_x),
    .win_y      (win_y),
    .frame_done (frame_done),
    .frame_abort(frame_abort),
    .line_err   (line_err),
    .state_dbg  (state_dbg)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (win_valid) begin
        n_valid++;
        check("valid_after_clken", 32'(last_pix), 32'd1);
        check("window_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_e = exp_q.pop_front();
          check("win_xy", 32'({win_x, win_y}), 32'(exp_e));
        end
      end
      if (frame_done)  n_done++;
      if (frame_abort) n_abort++;
    end
    last_pix = m_href & m_clken;
  end

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Window centre = (pixel index - 1, line index - 1) for line >= 2, pixel >= 2.
  task automatic drive_line(input int l, input int len, input int mode, input bit drop_vs);
    int p;
    bit tog;
    bit ce;
    p   = 0;
    tog = 1'b1;
    m_href = 1'b1;
    while (p < len) begin
      ce  = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      m_clken = ce;
      if (ce) begin
        if (l >= 2 && l < V && p >= 2) begin
          exp_q.push_back({10'(p - 1), 10'(l - 1)});
          n_push++;
        end
        p++;
      end
      tick();
    end
    m_href  = 1'b0;
    m_clken = 1'b0;
    if (drop_vs) m_vsync = 1'b0;
    repeat ($urandom_range(2, 4)) begin
      m_clken = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    m_clken = 1'b0;
  endtask

  task automatic start_frame();
    n_valid = 0;
    n_push  = 0;
    n_done  = 0;
    n_abort = 0;
    m_vsync = 1'b1;
    tick();
    @(negedge clk);
    check("xy_clear_on_vs_rise", 32'({win_x, win_y}), 32'd0);
    tick();
    tick();
  endtask

  task automatic run_frame(input int n_lines, input int short_line, input int short_len,
                           input int mode, input bit together, input int glitch_after);
    int seg;
    int len;
    int exp_done;
    int exp_abort;
    bit err_exp;
    seg       = 0;
    exp_done  = 0;
    exp_abort = 0;
    err_exp   = 1'b0;
    start_frame();
    for (int l = 0; l < n_lines; l++) begin
      if (glitch_after > 0 && l == glitch_after) begin
        m_vsync = 1'b0;
        tick();
        m_vsync = 1'b1;
        tick();
        tick();
        if (seg >= V) exp_done++; else exp_abort++;
        seg     = 0;
        err_exp = 1'b0;
      end
      len = (l == short_line) ? short_len : H;
      if (len != H) err_exp = 1'b1;
      drive_line(seg, len, mode, together && (l == n_lines - 1));
      seg++;
    end
    m_vsync = 1'b0;
    if (seg >= V) exp_done++; else exp_abort++;
    repeat (4) tick();
    @(negedge clk);
`ifndef VIPMOD_WIN_ERR_EN
    err_exp = 1'b0;
`endif
    check("valid_count", 32'(n_valid), 32'(n_push));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("frame_done_count", 32'(n_done), 32'(exp_done));
    check("frame_abort_count", 32'(n_abort), 32'(exp_abort));
    check("line_err", 32'(line_err), 32'(err_exp));
    check("state_idle", 32'(state_dbg), 32'd0);
    tick();
  endtask

  initial begin
    rst_n   = 1'b0;
    m_vsync = 1'b0;
    m_href  = 1'b0;
    m_clken = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({win_vsync, win_href, win_valid, win_x, win_y,
                               frame_done, frame_abort, line_err, state_dbg}), 32'd0);
    tick();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick();

    // nominal, clken every cycle
    run_frame(V, -1, H, 0, 1'b0, 0);
    check("nominal_24_windows", 32'(n_valid), 32'd24);
    // clken every other cycle
    run_frame(V, -1, H, 1, 1'b0, 0);
    check("halfrate_24_windows", 32'(n_valid), 32'd24);
    // vsync drops after 3 lines, then a normal frame
    run_frame(3, -1, H, 0, 1'b0, 0);
    run_frame(V, -1, H, 0, 1'b0, 0);
    // short line of 7 pixels
    run_frame(V, 3, 7, 0, 1'b0, 0);
    // hs_fall and vs_fall together on the last line
    run_frame(V, -1, H, 0, 1'b1, 0);
    // vsync glitch while ACTIVE restarts the frame
    run_frame(3 + V, -1, H, 0, 1'b0, 3);

    // async reset mid-ACTIVE
    start_frame();
    for (int l = 0; l < 3; l++) drive_line(l, H, 0, 1'b0);
    drive_line(3, 4, 0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("reset_mid_frame_outputs", 32'({win_vsync, win_href, win_valid, win_x, win_y,
                                         frame_done, frame_abort, line_err, state_dbg}), 32'd0);
    check("reset_queue_empty", 32'(exp_q.size()), 32'd0);
    check("reset_no_pulses", 32'(n_done + n_abort), 32'd0);
    exp_q.delete();
    m_vsync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    run_frame(V, -1, H, 0, 1'b0, 0);
    check("post_reset_24_windows", 32'(n_valid), 32'd24);

    // randomized frames
    for (int r = 0; r < 8; r++) begin
      run_frame($urandom_range(1, V + 2),
                ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, V - 1)) : -1,
                $urandom_range(3, H + 2), 2, 1'($urandom_range(0, 1)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
